// File: rtl/decode_stage.sv
// RV32I decode stage: one pipeline register between fetch and execute with a
// valid/ready handshake, flush, illegal-instruction detection, optional
// M-extension acceptance and a saturating illegal-instruction counter.
module decode_stage #(
   parameter int PC_W     = 32,
   parameter int ENABLE_M = 0,
   parameter int CNT_W    = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [31:0]      in_inst,
   input  logic [PC_W-1:0]  in_pc,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [PC_W-1:0]  out_pc,
   output logic [4:0]       out_opcode,
   output logic [2:0]       out_funct3,
   output logic             out_funct7_5,
   output logic             out_is_m,
   output logic [4:0]       out_rd,
   output logic [4:0]       out_rs1,
   output logic [4:0]       out_rs2,
   output logic             out_rd_we,
   output logic [31:0]      out_imm,
   output logic             out_illegal,
   output logic [CNT_W-1:0] ill_cnt
);

   // Major opcodes, inst[6:2] (inst[1:0] must be 2'b11 for a 32-bit encoding)
   localparam logic [4:0] OPC_LOAD   = 5'b00000;
   localparam logic [4:0] OPC_FENCE  = 5'b00011;
   localparam logic [4:0] OPC_OPIMM  = 5'b00100;
   localparam logic [4:0] OPC_AUIPC  = 5'b00101;
   localparam logic [4:0] OPC_STORE  = 5'b01000;
   localparam logic [4:0] OPC_OP     = 5'b01100;
   localparam logic [4:0] OPC_LUI    = 5'b01101;
   localparam logic [4:0] OPC_BRANCH = 5'b11000;
   localparam logic [4:0] OPC_JALR   = 5'b11001;
   localparam logic [4:0] OPC_JAL    = 5'b11011;
   localparam logic [4:0] OPC_SYSTEM = 5'b11100;

   localparam logic [2:0] IMM_NONE = 3'd0;
   localparam logic [2:0] IMM_I    = 3'd1;
   localparam logic [2:0] IMM_S    = 3'd2;
   localparam logic [2:0] IMM_B    = 3'd3;
   localparam logic [2:0] IMM_U    = 3'd4;
   localparam logic [2:0] IMM_J    = 3'd5;

   localparam logic [6:0] F7_ZERO = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   localparam logic             M_ON    = (ENABLE_M != 0);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

   function automatic logic [31:0] imm_i(input logic [31:0] i);
      return {{20{i[31]}}, i[31:20]};
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] i);
      return {{20{i[31]}}, i[31:25], i[11:7]};
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      return {{19{i[31]}}, i[31], i[7], i[30:25], i[11:8], 1'b0};
   endfunction

   function automatic logic [31:0] imm_u(input logic [31:0] i);
      return {i[31:12], 12'h000};
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] i);
      return {{11{i[31]}}, i[31], i[19:12], i[20], i[30:21], 1'b0};
   endfunction

   logic [4:0]  opc;
   logic [2:0]  f3;
   logic [6:0]  f7;
   logic        is32;
   logic        legal;
   logic        use_rd;
   logic        use_rs1;
   logic        use_rs2;
   logic        writes;
   logic        m_op;
   logic        alt_bit;
   logic [2:0]  imm_sel;
   logic [31:0] imm_raw;
   logic [4:0]  dec_rd;
   logic [4:0]  dec_rs1;
   logic [4:0]  dec_rs2;
   logic        dec_we;
   logic [31:0] dec_imm;
   logic        dec_is_m;
   logic        load;

   assign opc  = in_inst[6:2];
   assign f3   = in_inst[14:12];
   assign f7   = in_inst[31:25];
   assign is32 = (in_inst[1:0] == 2'b11);

   assign in_ready = !out_valid || out_ready;
   assign load     = in_valid && in_ready && !flush;

   // Classify the incoming word: legality, which register fields it uses, immediate format
   always_comb begin
      legal   = 1'b0;
      use_rd  = 1'b0;
      use_rs1 = 1'b0;
      use_rs2 = 1'b0;
      writes  = 1'b0;
      m_op    = 1'b0;
      alt_bit = 1'b0;
      imm_sel = IMM_NONE;
      if (is32) begin
         case (opc)
            OPC_LUI, OPC_AUIPC: begin
               legal = 1'b1; use_rd = 1'b1; writes = 1'b1; imm_sel = IMM_U;
            end
            OPC_JAL: begin
               legal = 1'b1; use_rd = 1'b1; writes = 1'b1; imm_sel = IMM_J;
            end
            OPC_JALR: begin
               legal = (f3 == 3'b000); use_rd = 1'b1; use_rs1 = 1'b1;
               writes = 1'b1; imm_sel = IMM_I;
            end
            OPC_BRANCH: begin
               legal = (f3 != 3'b010) && (f3 != 3'b011);
               use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = IMM_B;
            end
            OPC_LOAD: begin
               case (f3)
                  3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
                  default:                                legal = 1'b0;
               endcase
               use_rd = 1'b1; use_rs1 = 1'b1; writes = 1'b1; imm_sel = IMM_I;
            end
            OPC_STORE: begin
               legal = (f3 <= 3'b010); use_rs1 = 1'b1; use_rs2 = 1'b1; imm_sel = IMM_S;
            end
            OPC_OPIMM: begin
               use_rd = 1'b1; use_rs1 = 1'b1; writes = 1'b1; imm_sel = IMM_I;
               if (f3 == 3'b001) begin
                  legal = (f7 == F7_ZERO);
               end else if (f3 == 3'b101) begin
                  legal   = (f7 == F7_ZERO) || (f7 == F7_ALT);
                  alt_bit = in_inst[30];
               end else begin
                  legal = 1'b1;
               end
            end
            OPC_OP: begin
               use_rd = 1'b1; use_rs1 = 1'b1; use_rs2 = 1'b1; writes = 1'b1;
               alt_bit = in_inst[30];
               if (f7 == F7_ZERO) begin
                  legal = 1'b1;
               end else if (f7 == F7_ALT) begin
                  // only ADD/SUB and SRL/SRA have an alternate form
                  legal = (f3 == 3'b000) || (f3 == 3'b101);
               end else if (f7 == F7_MUL) begin
                  legal = M_ON;
                  m_op  = M_ON;
               end else begin
                  legal = 1'b0;
               end
            end
            OPC_FENCE: begin
               // rd field is registered but never written
               legal = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; imm_sel = IMM_I;
            end
            OPC_SYSTEM: begin
               legal = 1'b1; use_rd = 1'b1; use_rs1 = 1'b1; writes = 1'b1; imm_sel = IMM_I;
            end
            default: begin
               legal = 1'b0;
            end
         endcase
      end else begin
         legal = 1'b0;
      end
   end

   // Build the decoded fields; illegal words keep their fields but lose imm and write enable
   always_comb begin
      case (imm_sel)
         IMM_I:   imm_raw = imm_i(in_inst);
         IMM_S:   imm_raw = imm_s(in_inst);
         IMM_B:   imm_raw = imm_b(in_inst);
         IMM_U:   imm_raw = imm_u(in_inst);
         IMM_J:   imm_raw = imm_j(in_inst);
         default: imm_raw = 32'h0000_0000;
      endcase
      dec_rd   = use_rd  ? in_inst[11:7]  : 5'd0;
      dec_rs1  = use_rs1 ? in_inst[19:15] : 5'd0;
      dec_rs2  = use_rs2 ? in_inst[24:20] : 5'd0;
      dec_imm  = legal ? imm_raw : 32'h0000_0000;
      dec_we   = legal && writes && (in_inst[11:7] != 5'd0);
      dec_is_m = legal && m_op;
   end

   // Pipeline register, handshake state and saturating illegal counter
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid    <= 1'b0;
         out_pc       <= {PC_W{1'b0}};
         out_opcode   <= 5'd0;
         out_funct3   <= 3'd0;
         out_funct7_5 <= 1'b0;
         out_is_m     <= 1'b0;
         out_rd       <= 5'd0;
         out_rs1      <= 5'd0;
         out_rs2      <= 5'd0;
         out_rd_we    <= 1'b0;
         out_imm      <= 32'h0000_0000;
         out_illegal  <= 1'b0;
         ill_cnt      <= {CNT_W{1'b0}};
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (load) begin
         out_valid    <= 1'b1;
         out_pc       <= in_pc;
         out_opcode   <= opc;
         out_funct3   <= f3;
         out_funct7_5 <= alt_bit;
         out_is_m     <= dec_is_m;
         out_rd       <= dec_rd;
         out_rs1      <= dec_rs1;
         out_rs2      <= dec_rs2;
         out_rd_we    <= dec_we;
         out_imm      <= dec_imm;
         out_illegal  <= !legal;
         if (!legal && (ill_cnt != CNT_MAX)) begin
            ill_cnt <= ill_cnt + CNT_ONE;
         end else begin
            ill_cnt <= ill_cnt;
         end
      end else if (out_ready) begin
         out_valid <= 1'b0;
      end else begin
         out_valid <= out_valid;
      end
   end

endmodule
